// File: rtl/prefix_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prefix_adder_ctrl_pkg
// Description : Shared constants and types for the shared prefix adder front end.
// Revision    : 1.0 - initial release
// ============================================================================
package prefix_adder_ctrl_pkg;

    localparam int NUM_REQ_DEF     = 4;
    localparam int WIDTH_DEF       = 32;
    localparam int ADD_LATENCY_DEF = 2;
    localparam int NUM_REQ_MAX     = 8;

    // Tag width covers the largest supported requester count.
    typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_idx_t;

    typedef struct packed {
        logic     vld;
        req_idx_t tag;
    } inflight_t;

endpackage
`default_nettype wire

// File: rtl/prefix_adder.sv
`default_nettype none
// ============================================================================
// Module      : prefix_adder
// Description : Kogge-Stone adder followed by LATENCY register stages, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module prefix_adder #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    function automatic logic [WIDTH-1:0] ks_sum(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] p0;
        g  = a & b;
        p  = a ^ b;
        p0 = p;
        // Bits below the span d already hold their full prefix and ignore p.
        for (int d = 1; d < WIDTH; d = d * 2) begin
            g = g | (p & (g << d));
            p = p & (p << d);
        end
        return p0 ^ {g[WIDTH-2:0], 1'b0};
    endfunction

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_stage [LATENCY];

    assign w_sum = ks_sum(i_a, i_b);

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        if (s == 0) begin : g_first
            always_ff @(posedge clk) begin
                r_stage[s] <= w_sum;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_sum = r_stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/prefix_adder_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin grant scan with pointer register and hold gating.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import prefix_adder_ctrl_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic               i_hold,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_accept,
    output req_idx_t           o_idx
);

    localparam logic [NUM_REQ-1:0] c_one     = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam req_idx_t           c_idx_one = req_idx_t'(1);

    req_idx_t             r_ptr;
    logic [2*NUM_REQ-1:0] w_dbl;
    int                   w_off;
    int                   w_sum;
    req_idx_t             w_idx;
    logic                 w_any;

    // Rotate so bit 0 is the requester just after the pointer; the lowest set
    // bit of the rotated vector is the winner.
    always_comb begin
        w_dbl = {i_valid, i_valid} >> (r_ptr + c_idx_one);
        w_off = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_dbl[j]) begin
                w_off = j;
            end
        end
        w_sum = int'(r_ptr) + 1 + w_off;
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
        w_idx = req_idx_t'(w_sum);
        w_any = |i_valid;
    end

    assign o_grant  = (w_any && !i_hold && !rst) ? (c_one << w_idx) : '0;
    assign o_accept = |o_grant;
    assign o_idx    = w_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= req_idx_t'(NUM_REQ - 1);
        end else if (o_accept) begin
            r_ptr <= w_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prefix_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prefix_adder_arbiter
// Description : Shares one pipelined adder among requesters, returning tagged sums.
// Revision    : 1.0 - initial release
// ============================================================================
module prefix_adder_arbiter
    import prefix_adder_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int WIDTH       = WIDTH_DEF,
    parameter int ADD_LATENCY = ADD_LATENCY_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic                     hold,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_sum,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy
);

    localparam logic [NUM_REQ-1:0] c_one = {{(NUM_REQ-1){1'b0}}, 1'b1};

    req_idx_t                 w_idx;
    logic                     w_accept;
    logic [WIDTH-1:0]         w_sel_a;
    logic [WIDTH-1:0]         w_sel_b;
    inflight_t [ADD_LATENCY:0] r_pipe;
    inflight_t                w_last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (req_valid),
        .i_hold   (hold),
        .o_grant  (req_ready),
        .o_accept (w_accept),
        .o_idx    (w_idx)
    );

    assign w_sel_a = req_a[int'(w_idx)*WIDTH +: WIDTH];
    assign w_sel_b = req_b[int'(w_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a <= '0;
            add_b <= '0;
        end else if (w_accept) begin
            add_a <= w_sel_a;
            add_b <= w_sel_b;
        end
    end

    // One stage per adder edge plus the sampling edge; never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= inflight_t'{vld: w_accept, tag: w_idx};
            for (int s = 1; s <= ADD_LATENCY; s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    assign w_last = r_pipe[ADD_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= w_last.vld ? (c_one << w_last.tag) : '0;
            if (w_last.vld) begin
                rsp_data <= add_sum;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s <= ADD_LATENCY; s++) begin
            busy = busy | r_pipe[s].vld;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prefix_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefix_adder_arbiter
// Description : Randomized bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefix_adder_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           hold = 1'b0;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_sum;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;

    always #5 clk = ~clk;

    prefix_adder_arbiter #(
        .NUM_REQ     (N),
        .WIDTH       (W),
        .ADD_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .hold      (hold),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    prefix_adder #(
        .WIDTH   (W),
        .LATENCY (LAT)
    ) u_adder (
        .clk   (clk),
        .i_a   (add_a),
        .i_b   (add_b),
        .o_sum (add_sum)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pointer, last operands and a queue of outstanding ops,
    // each with the number of clock edges left until its response is visible.
    typedef struct {
        int           cnt;
        int           idx;
        logic [W-1:0] sum;
    } op_t;

    op_t          q[$];
    int           m_ptr = N - 1;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [N-1:0] e_rv;
    logic [N-1:0] e_rdy;
    logic [W-1:0] e_rd;
    logic         e_busy;
    int           g;

    function automatic int model_grant();
        int c;
        if (rst || hold) return -1;
        for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_ptr = N - 1;
            m_a   = '0;
            m_b   = '0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_add_a", add_a, 0);
            chk("rst_add_b", add_b, 0);
            chk("rst_req_ready", req_ready, 0);
        end else begin
            e_rv = '0;
            e_rd = '0;
            foreach (q[j]) q[j].cnt--;
            if (q.size() > 0 && q[0].cnt == 0) begin
                e_rv = N'(1) << q[0].idx;
                e_rd = q[0].sum;
                void'(q.pop_front());
            end
            e_busy = (q.size() > 0);
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_rv != 0) chk("rsp_data", rsp_data, e_rd);
            chk("busy", busy, e_busy);
            chk("add_a", add_a, m_a);
            chk("add_b", add_b, m_b);
            g     = model_grant();
            e_rdy = (g >= 0) ? (N'(1) << g) : '0;
            chk("req_ready", req_ready, e_rdy);
            if (g >= 0) begin
                m_ptr = g;
                m_a   = req_a[g*W +: W];
                m_b   = req_b[g*W +: W];
                // +1 accept edge, +LAT adder edges, +1 sampling edge
                q.push_back('{cnt: LAT + 2, idx: g, sum: m_a + m_b});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single op 1+1 from requester 0
        set_op(0, 32'd1, 32'd1);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (3) begin
            @(negedge clk);
            chk("t1_busy", busy, 1);
            chk("t1_no_rsp", rsp_valid, 0);
        end
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_data", rsp_data, 32'h0000_0002);
        chk("t1_busy_low", busy, 0);
        tick();

        // Wrap-around sum from requester 2
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("t2_rsp_valid", rsp_valid, 4'b0100);
        chk("t2_rsp_data", rsp_data, 32'h0000_0000);
        tick();

        // All requesters valid after a fresh reset: rotation 0,1,2,3,...
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, W'(i), W'(10 * i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t3_rr_order", req_ready, N'(1) << (k % N));
            tick();
        end
        req_valid = '0;
        repeat (5) tick();

        // Requester 1 alone for 5 back-to-back cycles, A=B=n
        for (int n = 0; n < 9; n++) begin
            if (n < 5) begin
                set_op(1, W'(n), W'(n));
                req_valid = 4'b0010;
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            if (n >= 4) begin
                chk("t4_rsp_valid", rsp_valid, 4'b0010);
                chk("t4_rsp_data", rsp_data, W'(2 * (n - 4)));
            end
            tick();
        end

        // Hold with two operations in flight
        set_op(0, 32'd100, 32'd1);
        set_op(1, 32'd200, 32'd2);
        req_valid = 4'b0011;
        tick();
        tick();
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_hold_ready", req_ready, 0);
            chk("t5_busy", busy, (k < 3) ? 1'b1 : 1'b0);
        end
        tick();
        hold = 1'b0;
        req_valid = '0;
        tick();

        // Reset one cycle after an accept; result must be discarded
        set_op(0, 32'd5, 32'd6);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("t6_ready_after_rst", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        repeat (6) tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) set_op(i, 32'hFFFF_FFFF, $urandom);
                else set_op(i, $urandom, $urandom);
            end
            req_valid = N'($urandom);
            hold      = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst       = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prefix_adder_arbiter.md
Name: prefix_adder_arbiter

Overview:
- Shares one pipelined 32-bit prefix adder between NUM_REQ requesters.
- Each requester uses a valid/ready handshake; a round-robin arbiter grants at most one per cycle.
- The block registers the granted operands into the adder and tracks each operation's requester index through a valid/tag shift register matched to the adder latency.
- It returns each sum to the originating requester; the adder itself has no valid or reset, so this block owns all sequencing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/sum width
- ADD_LATENCY, 2, adder latency in clock edges from operand change to stable Sum (must match the instantiated adder)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req_valid  input  NUM_REQ  per-requester operation request
- req_ready  output  NUM_REQ  one-hot grant, combinational
- req_a  input  NUM_REQ*WIDTH  per-requester operand A, packed; requester i uses [i*WIDTH +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  per-requester operand B, same packing
- hold  input  1  when high, no new grants; in-flight operations drain
- add_a  output  WIDTH  registered operand A to adder
- add_b  output  WIDTH  registered operand B to adder
- add_sum  input  WIDTH  adder Sum
- rsp_valid  output  NUM_REQ  one-hot, registered, one-cycle pulse per completed operation
- rsp_data  output  WIDTH  registered sum, valid only with rsp_valid
- busy  output  1  any operation issued and not yet responded

Behaviour:
- Reset (async, immediate):
  - req_ready=0, rsp_valid=0, rsp_data=0, add_a=0, add_b=0, busy=0.
  - Tag/valid pipeline cleared; round-robin pointer = NUM_REQ-1, so requester 0 has top priority after reset.
- Grant:
  - req_ready[i]=1 only if !hold, req_valid[i]=1, and i is the first requester with req_valid set scanning upward from pointer+1 modulo NUM_REQ.
  - At most one bit of req_ready is set. req_ready does not depend on any ready output.
- Accept: transfer occurs on an edge where req_valid[i]&&req_ready[i]. At that edge:
  - add_a/add_b load req_a[i]/req_b[i].
  - Stage 0 of the valid/tag pipeline loads {1,i}.
  - The pointer moves to i.
- No-accept edges: add_a/add_b hold their previous values; stage 0 loads valid=0. The pointer is unchanged.
- Pipeline and response:
  - Valid/tag pipeline has ADD_LATENCY+1 stages and shifts every edge unconditionally; no stall, no response backpressure.
  - For a transfer at edge k, add_sum is sampled at edge k+ADD_LATENCY+1. At that edge rsp_data<=add_sum and rsp_valid<=onehot(tag); rsp_valid deasserts on the next edge unless another operation completes.
  - Fixed latency: response visible ADD_LATENCY+1 cycles after acceptance (3 at default).
  - Throughput: one operation per cycle; back-to-back responses are in acceptance order.
- Requester obligations: req_a, req_b and req_valid stay stable until the handshake; the requester must accept rsp_valid whenever it occurs.
- busy = OR of all valid bits in the pipeline, combinational from registers.
- hold:
  - Asserting blocks grants in the same cycle (req_ready=0); the pointer is frozen.
  - In-flight operations complete normally; busy falls once drained.
- Boundary conditions:
  - Single requester continuously valid: granted every cycle.
  - All requesters valid: grants rotate 0,1,2,3,0…
  - Requester deasserting valid without a handshake: legal, no effect.
  - Reset mid-operation: in-flight results discarded, no rsp_valid after reset release until new operations complete the full latency.
  - Operand value wrap: sum is modulo 2^WIDTH (adder has no carry-out).

Decomposition:
- Package prefix_adder_ctrl_pkg holds:
  - constants NUM_REQ_DEF, WIDTH_DEF, ADD_LATENCY_DEF;
  - typedef req_idx_t = logic [$clog2(NUM_REQ)-1:0];
  - typedef struct packed {logic vld; req_idx_t tag;} inflight_t.
- Sub-module rr_arbiter contains the round-robin priority scan, pointer register and hold gating. The top level holds operand registers, the inflight_t shift register and the response register.
- Bench instantiates the real pipelined adder, clk period 10.

Test Plan:
- Reset, then req_valid=0001, req_a[0]=1, req_b[0]=1 → req_ready=0001 same cycle; rsp_valid=0001, rsp_data=00000002 exactly 3 cycles after the accept edge; busy high for those 3 cycles.
- Requester 2: A=FFFFFFFF, B=00000001 → rsp_valid=0100, rsp_data=00000000 (wrap).
- req_valid=1111 held 8 cycles, operands A=i, B=10*i → grant order 0,1,2,3,0,1,2,3; responses in same order with sums 0,11,22,33 repeating.
- Single requester 1 valid 5 consecutive cycles with A=n, B=n → 5 back-to-back rsp_valid=0010, data 0,2,4,6,8.
- hold=1 with req_valid=0011 and 2 ops in flight → req_ready=0; both in-flight results still return; busy drops 3 cycles after last accept.
- Assert rst one cycle after an accept → rsp_valid never pulses for that op; after release, req_valid=1000 gets grant (pointer reset, requester 3 only candidate).
